// File: rtl/img_pkg.sv
// ----------------------------------------------------------------------------
// img_pkg
//   Shared image-geometry constants and FSM encodings for the BRAM fetch and
//   write-back paths.
//
//   Contents:
//     IMG_MAX_ROW / IMG_MAX_COL  default frame geometry (rows x columns)
//     IMG_FRAME_PIXELS           pixels per frame
//     IMG_ADDR_W                 BRAM address width
//     IMG_CNT_W                  width of the row/column counters
//     IMG_THRESH                 default binarize threshold
//     ST_IDLE/ST_WRITE/ST_DONE   write-back FSM state encodings
//     binarize()                 threshold helper (used when MEMWB_BINARIZE_EN)
// ----------------------------------------------------------------------------
package img_pkg;

    localparam int IMG_MAX_ROW      = 540;
    localparam int IMG_MAX_COL      = 540;
    localparam int IMG_FRAME_PIXELS = IMG_MAX_ROW * IMG_MAX_COL;
    localparam int IMG_ADDR_W       = 19;
    localparam int IMG_CNT_W        = 10;
    localparam int IMG_THRESH       = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Pixels at or above the threshold become full white, the rest black.
    function automatic logic [7:0] binarize(input logic [7:0] pix, input int thresh);
        return (int'(pix) >= thresh) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/memory_writeback_controller_rowcol_counter.sv
// ----------------------------------------------------------------------------
// rowcol_counter
//   Raster-order row/column position counter. The column advances on every
//   enabled cycle and wraps MAX_COL-1 -> 0, carrying into the row; the row
//   wraps MAX_ROW-1 -> 0 at the end of the frame. Shared by fetch and
//   write-back paths.
//
//   Ports:
//     clk      in   clock
//     rst_n    in   synchronous reset, active-low
//     clear_i  in   synchronous clear to (0,0); wins over en_i
//     en_i     in   advance one pixel
//     row_o    out  current row
//     col_o    out  current column
//     last_o   out  current position is the final pixel of the frame
// ----------------------------------------------------------------------------
module rowcol_counter #(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_o
);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             colWrap;
    logic             rowWrap;

    assign colWrap = (col_q == CNT_W'(MAX_COL - 1));
    assign rowWrap = (row_q == CNT_W'(MAX_ROW - 1));

    // Next position: column first, row only advances on a column wrap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (colWrap) begin
                col_d = '0;
                row_d = rowWrap ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = colWrap && rowWrap;

endmodule

// File: rtl/memory_writeback_controller.sv
// ----------------------------------------------------------------------------
// memory_writeback_controller
//   Write-side BRAM controller. Takes the 8-bit processed pixel stream and
//   writes it raster-order into the output BRAM through a write-only port,
//   tracking frame position and signalling frame completion.
//
//   Optional feature macro: MEMWB_BINARIZE_EN
//     defined     -> written data is binarized against THRESH (00 / FF)
//     not defined -> written data is the pixel unchanged
//
//   Ports:
//     clk           in   clock
//     rst_n         in   synchronous reset, active-low
//     start_i       in   frame start strobe (taken only in IDLE)
//     data_i        in   processed pixel
//     data_en_i     in   data_i valid this cycle, no backpressure
//     enb_o         out  BRAM enable
//     web_o         out  BRAM write enable
//     addrb_o       out  BRAM write address
//     dinb_o        out  BRAM write data
//     busy_o        out  high while in WRITE
//     wr_done_o     out  one-cycle pulse, frame fully written
//     err_o         out  sticky, pixel arrived while not accepting
//     cnt_wr_row_o  out  row of the pixel on addrb_o
//     cnt_wr_col_o  out  column of the pixel on addrb_o
// ----------------------------------------------------------------------------
module memory_writeback_controller
    import img_pkg::*;
#(
    parameter int MAX_ROW = IMG_MAX_ROW,
    parameter int MAX_COL = IMG_MAX_COL,
    parameter int ADDR_W  = IMG_ADDR_W
`ifdef MEMWB_BINARIZE_EN
    ,
    parameter int THRESH  = IMG_THRESH
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        data_i,
    input  logic              data_en_i,
    output logic              enb_o,
    output logic              web_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [7:0]        dinb_o,
    output logic              busy_o,
    output logic              wr_done_o,
    output logic              err_o,
    output logic [9:0]        cnt_wr_row_o,
    output logic [9:0]        cnt_wr_col_o
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [7:0]        dinb_q, dinb_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        col_q, col_d;

    logic              accept;
    logic              cntClear;
    logic [9:0]        cntRow;
    logic [9:0]        cntCol;
    logic              cntLast;
    logic [7:0]        pixel;

    // full_q marks that the final pixel has been issued; WRITE is held for
    // one more cycle so the done pulse lands after the last write strobe.
    assign accept   = (state_q == ST_WRITE) && !full_q && data_en_i;
    assign cntClear = (state_q == ST_IDLE) && start_i;

`ifdef MEMWB_BINARIZE_EN
    assign pixel = binarize(data_i, THRESH);
`else
    assign pixel = data_i;
`endif

    rowcol_counter #(
        .MAX_ROW (MAX_ROW),
        .MAX_COL (MAX_COL),
        .CNT_W   (10)
    ) u_rowcol (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cntClear),
        .en_i    (accept),
        .row_o   (cntRow),
        .col_o   (cntCol),
        .last_o  (cntLast)
    );

    // FSM plus write-port next state. The BRAM-facing registers only change
    // on an accepted pixel so address/data hold between writes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        full_d  = full_q;
        err_d   = err_q;
        wen_d   = 1'b0;
        addrb_d = addrb_q;
        dinb_d  = dinb_q;
        row_d   = row_q;
        col_d   = col_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WRITE;
                    ptr_d   = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                if (full_q) begin
                    state_d = ST_DONE;
                end else if (accept) begin
                    wen_d   = 1'b1;
                    addrb_d = ptr_q;
                    dinb_d  = pixel;
                    row_d   = cntRow;
                    col_d   = cntCol;
                    // The pointer parks on the final address so it never
                    // leaves the frame.
                    if (cntLast) begin
                        full_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                full_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A dropped pixel is flagged even in the cycle a start is taken.
        if (data_en_i && !accept) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            addrb_q <= '0;
            dinb_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            addrb_q <= addrb_d;
            dinb_q  <= dinb_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign enb_o        = wen_q;
    assign web_o        = wen_q;
    assign addrb_o      = addrb_q;
    assign dinb_o       = dinb_q;
    assign busy_o       = (state_q == ST_WRITE);
    assign wr_done_o    = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign cnt_wr_row_o = row_q;
    assign cnt_wr_col_o = col_q;

endmodule

// File: tb/tb_memory_writeback_controller.sv
// ----------------------------------------------------------------------------
// tb_memory_writeback_controller
//   Directed bench for memory_writeback_controller on a 4x5 frame.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled 1 time unit after the next rising edge.
// ----------------------------------------------------------------------------
module tb_memory_writeback_controller;

    localparam int ROWS   = 4;
    localparam int COLS   = 5;
    localparam int PIXELS = ROWS * COLS;
    localparam int AW     = 19;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [7:0]    data_i;
    logic          data_en_i;
    logic          enb_o;
    logic          web_o;
    logic [AW-1:0] addrb_o;
    logic [7:0]    dinb_o;
    logic          busy_o;
    logic          wr_done_o;
    logic          err_o;
    logic [9:0]    cnt_wr_row_o;
    logic [9:0]    cnt_wr_col_o;

    int compared;
    int mismatched;

    memory_writeback_controller #(
        .MAX_ROW (ROWS),
        .MAX_COL (COLS),
        .ADDR_W  (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .data_i       (data_i),
        .data_en_i    (data_en_i),
        .enb_o        (enb_o),
        .web_o        (web_o),
        .addrb_o      (addrb_o),
        .dinb_o       (dinb_o),
        .busy_o       (busy_o),
        .wr_done_o    (wr_done_o),
        .err_o        (err_o),
        .cnt_wr_row_o (cnt_wr_row_o),
        .cnt_wr_col_o (cnt_wr_col_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected written byte for a raw pixel in this build.
    function automatic logic [7:0] expPix(input logic [7:0] p);
`ifdef MEMWB_BINARIZE_EN
        return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        start_i   = 1'b0;
        data_en_i = 1'b0;
        data_i    = 8'h00;
        repeat (3) step();
        compared++;
        if ({enb_o, web_o, busy_o, wr_done_o, err_o} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {enb_o, web_o, busy_o, wr_done_o, err_o});
        end
        compared++;
        if (addrb_o !== '0 || dinb_o !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_port: addr %0d din %h expected 0 00", addrb_o, dinb_o);
        end
        compared++;
        if (cnt_wr_row_o !== 10'd0 || cnt_wr_col_o !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_rowcol: got (%0d,%0d) expected (0,0)", cnt_wr_row_o, cnt_wr_col_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        compared++;
        if (busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy: got %b expected 1", busy_o);
        end
        for (int k = 0; k < PIXELS; k++) begin
            data_en_i = 1'b1;
            data_i    = 8'(k * 9 + 3);
            step();
            compared++;
            if (web_o !== 1'b1 || enb_o !== 1'b1 || addrb_o !== AW'(k) || dinb_o !== expPix(8'(k * 9 + 3))) begin
                mismatched++;
                $display("[TB] FAIL b2b_write%0d: web %b enb %b addr %0d din %h expected 1 1 %0d %h",
                         k, web_o, enb_o, addrb_o, dinb_o, k, expPix(8'(k * 9 + 3)));
            end
            compared++;
            if (cnt_wr_row_o !== 10'(k / COLS) || cnt_wr_col_o !== 10'(k % COLS) || wr_done_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL b2b_rowcol%0d: got (%0d,%0d) done %b expected (%0d,%0d) done 0",
                         k, cnt_wr_row_o, cnt_wr_col_o, wr_done_o, k / COLS, k % COLS);
            end
        end
        data_en_i = 1'b0;
        step();
        compared++;
        if (wr_done_o !== 1'b1 || busy_o !== 1'b0 || web_o !== 1'b0 || addrb_o !== AW'(PIXELS - 1)) begin
            mismatched++;
            $display("[TB] FAIL b2b_done: done %b busy %b web %b addr %0d expected 1 0 0 %0d",
                     wr_done_o, busy_o, web_o, addrb_o, PIXELS - 1);
        end
        step();
        compared++;
        if (wr_done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_idle: done %b busy %b err %b expected 0 0 0", wr_done_o, busy_o, err_o);
        end
    endtask

    task automatic test_gapped();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < PIXELS; k++) begin
            data_en_i = 1'b1;
            data_i    = 8'(8'h40 + k);
            step();
            compared++;
            if (web_o !== 1'b1 || addrb_o !== AW'(k) || dinb_o !== expPix(8'(8'h40 + k))) begin
                mismatched++;
                $display("[TB] FAIL gap_write%0d: web %b addr %0d din %h expected 1 %0d %h",
                         k, web_o, addrb_o, dinb_o, k, expPix(8'(8'h40 + k)));
            end
            data_en_i = 1'b0;
            for (int g = 0; g < 2; g++) begin
                step();
                compared++;
                if (web_o !== 1'b0 || addrb_o !== AW'(k) ||
                    wr_done_o !== ((k == PIXELS - 1) && (g == 0))) begin
                    mismatched++;
                    $display("[TB] FAIL gap_idle%0d_%0d: web %b addr %0d done %b expected 0 %0d %b",
                             k, g, web_o, addrb_o, wr_done_o, k, (k == PIXELS - 1) && (g == 0));
                end
            end
        end
    endtask

    task automatic test_idle_error();
        data_en_i = 1'b1;
        data_i    = 8'hAA;
        step();
        data_en_i = 1'b0;
        compared++;
        if (web_o !== 1'b0 || err_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL idle_err_set: web %b err %b expected 0 1", web_o, err_o);
        end
        repeat (3) step();
        compared++;
        if (err_o !== 1'b1 || web_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_err_sticky: err %b web %b expected 1 0", err_o, web_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        compared++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL idle_err_clear: err %b busy %b expected 0 1", err_o, busy_o);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        // Start with a simultaneous pixel: start taken, pixel dropped.
        start_i   = 1'b1;
        data_en_i = 1'b1;
        data_i    = 8'h11;
        step();
        compared++;
        if (busy_o !== 1'b1 || err_o !== 1'b1 || web_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL start_with_data: busy %b err %b web %b expected 1 1 0", busy_o, err_o, web_o);
        end
        // start_i stays high here and must be ignored in WRITE.
        data_i = 8'h22;
        step();
        start_i = 1'b0;
        data_i  = 8'h33;
        step();
        data_en_i = 1'b0;
        compared++;
        if (web_o !== 1'b1 || addrb_o !== AW'(1) || dinb_o !== expPix(8'h33) || err_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL start_ignored: web %b addr %0d din %h err %b expected 1 1 %h 1",
                     web_o, addrb_o, dinb_o, err_o, expPix(8'h33));
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midframe();
        int doneSeen;
        int cycles;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        data_en_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            data_i = 8'(k);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        compared++;
        if (web_o !== 1'b0 || busy_o !== 1'b0 || addrb_o !== '0 || cnt_wr_col_o !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL midrst_abort: web %b busy %b addr %0d col %0d expected 0 0 0 0",
                     web_o, busy_o, addrb_o, cnt_wr_col_o);
        end
        doneSeen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (web_o !== 1'b0 || wr_done_o !== 1'b0) doneSeen++;
        end
        data_en_i = 1'b0;
        compared++;
        if (doneSeen !== 0 || err_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midrst_quiet: activity %0d err %b expected 0 1", doneSeen, err_o);
        end
        start_i = 1'b1;
        step();
        start_i   = 1'b0;
        data_en_i = 1'b1;
        data_i    = 8'h5A;
        step();
        compared++;
        if (web_o !== 1'b1 || addrb_o !== '0) begin
            mismatched++;
            $display("[TB] FAIL midrst_restart: web %b addr %0d expected 1 0", web_o, addrb_o);
        end
        cycles = 0;
        while (wr_done_o !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        data_en_i = 1'b0;
        compared++;
        if (wr_done_o !== 1'b1 || addrb_o !== AW'(PIXELS - 1) || cycles !== PIXELS) begin
            mismatched++;
            $display("[TB] FAIL midrst_done: done %b addr %0d cycles %0d expected 1 %0d %0d",
                     wr_done_o, addrb_o, cycles, PIXELS - 1, PIXELS);
        end
        step();
    endtask

    task automatic test_binarize();
        logic [7:0] pix [4];
        logic [7:0] want [4];
        pix[0] = 8'd127;
        pix[1] = 8'd128;
        pix[2] = 8'd255;
        pix[3] = 8'd0;
`ifdef MEMWB_BINARIZE_EN
        want[0] = 8'h00;
        want[1] = 8'hFF;
        want[2] = 8'hFF;
        want[3] = 8'h00;
`else
        want[0] = 8'd127;
        want[1] = 8'd128;
        want[2] = 8'd255;
        want[3] = 8'd0;
`endif
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_en_i = 1'b1;
            data_i    = pix[i];
            step();
            compared++;
            if (web_o !== 1'b1 || addrb_o !== AW'(i) || dinb_o !== want[i]) begin
                mismatched++;
                $display("[TB] FAIL binarize%0d: web %b addr %0d din %h expected 1 %0d %h",
                         i, web_o, addrb_o, dinb_o, i, want[i]);
            end
        end
        data_en_i = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_idle_error();
        test_reset_midframe();
        test_binarize();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
